// File: rtl/nic8_pkg.sv
// Shared types for the nic8 data-RAM path.
//   ram_state_t : bus-sequencer phases (IDLE, SETUP, STROBE, HOLD)
//   ram_req_t   : one byte request as carried through the skid buffer
//   RAM_WS_MAX  : largest strobe extension the 4-bit wait counter can hold
package nic8_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        HOLD   = 2'd3
    } ram_state_t;

    typedef struct packed {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
    } ram_req_t;

    localparam int unsigned RAM_WS_MAX = 15;

endpackage

// File: rtl/ram_req_skid.sv
// One-entry request buffer in front of the RAM sequencer.
//   in_valid/in_ready/in_req : upstream request channel
//   out_valid/out_req        : oldest pending request (buffered entry first,
//                              otherwise the live upstream request)
//   out_pop                  : consumer takes out_req this cycle
//   full                     : an entry is buffered
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid must not depend on ready, and ready is simply "buffer
// empty", so it never depends on the upstream valid.
module ram_req_skid
    import nic8_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    input  logic     in_valid,
    output logic     in_ready,
    input  ram_req_t in_req,
    output logic     out_valid,
    output ram_req_t out_req,
    input  logic     out_pop,
    output logic     full
);

    logic     full_q, full_d;
    ram_req_t req_q, req_d;

    assign in_ready  = !full_q;
    assign full      = full_q;
    // The buffered entry is always older than anything upstream.
    assign out_valid = full_q || in_valid;
    assign out_req   = full_q ? req_q : in_req;

    always_comb begin
        full_d = full_q;
        req_d  = req_q;
        if (full_q) begin
            if (out_pop) begin
                full_d = 1'b0;
            end
        end else if (in_valid && !out_pop) begin
            // Consumer busy: park the request. When the consumer pops an
            // empty buffer the request passes straight through instead.
            full_d = 1'b1;
            req_d  = in_req;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            full_q <= 1'b0;
            req_q  <= '0;
        end else begin
            full_q <= full_d;
            req_q  <= req_d;
        end
    end

endmodule

// File: rtl/ram_master.sv
// Bus initiator for the 256-byte data RAM.
//   req_valid/req_ready/req_write/req_addr/req_wdata : core request channel
//   rd_valid/rd_data : one-cycle read-return pulse, rd_data held afterwards
//   busy             : sequencer active or a request is buffered
//   addr/data        : RAM address and tri-state data bus
//   outputEnable     : RAM read enable (active-high)
//   writeEnableBar   : RAM write enable (active-low)
//   dbg_state        : current sequencer phase
//
// Each access runs SETUP, STROBE (1+WAIT_STATES cycles), HOLD, then one IDLE
// cycle. All RAM-side controls are registered and computed from the next
// state so they change cleanly on the clock edge that enters each phase.
module ram_master
    import nic8_pkg::*;
#(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_write,
    input  logic [7:0] req_addr,
    input  logic [7:0] req_wdata,
    output logic       rd_valid,
    output logic [7:0] rd_data,
    output logic       busy,
    output logic [7:0] addr,
    inout  wire  [7:0] data,
    output logic       outputEnable,
    output logic       writeEnableBar,
    output ram_state_t dbg_state
);

    localparam int unsigned WS_CLAMP = (WAIT_STATES > RAM_WS_MAX) ? RAM_WS_MAX : WAIT_STATES;
    localparam logic [3:0]  WS_CNT   = WS_CLAMP[3:0];

    ram_state_t state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    ram_req_t   act_q, act_d;
    logic       oe_q, oe_d;
    logic       web_q, web_d;
    logic       drive_q, drive_d;
    logic       rd_valid_q, rd_valid_d;
    logic [7:0] rd_data_q, rd_data_d;

    ram_req_t   req_in;
    ram_req_t   pend_req;
    logic       pend_valid;
    logic       pop;
    logic       skid_full;

    assign req_in = {req_write, req_addr, req_wdata};

    ram_req_skid u_skid (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (req_valid),
        .in_ready  (req_ready),
        .in_req    (req_in),
        .out_valid (pend_valid),
        .out_req   (pend_req),
        .out_pop   (pop),
        .full      (skid_full)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        act_d     = act_q;
        rd_data_d = rd_data_q;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (pend_valid) begin
                    pop     = 1'b1;
                    act_d   = pend_req;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = WS_CNT;
            end
            STROBE: begin
                if (cnt_q == 4'd0) begin
                    state_d = HOLD;
                    // Last strobe edge: RAM output has had the whole strobe to settle.
                    if (!act_q.write) begin
                        rd_data_d = data;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // HOLD drops both strobes, so a read's outputEnable never meets the
        // data drive of the following write.
        oe_d       = !act_d.write && ((state_d == SETUP) || (state_d == STROBE));
        web_d      = !(act_d.write && (state_d == STROBE));
        drive_d    = act_d.write && (state_d != IDLE);
        rd_valid_d = !act_d.write && (state_d == HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            act_q      <= '0;
            oe_q       <= 1'b0;
            web_q      <= 1'b1;
            drive_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            act_q      <= act_d;
            oe_q       <= oe_d;
            web_q      <= web_d;
            drive_q    <= drive_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign data           = drive_q ? act_q.wdata : 8'bz;
    assign addr           = act_q.addr;
    assign outputEnable   = oe_q;
    assign writeEnableBar = web_q;
    assign rd_valid       = rd_valid_q;
    assign rd_data        = rd_data_q;
    assign busy           = (state_q != IDLE) || skid_full;
    assign dbg_state      = state_q;

endmodule

// File: tb/tb_ram_master.sv
// Bench for ram_master: one instance with no wait states (u=0) and one with
// three (u=1), each attached to a behavioural 256-byte RAM.
module tb_ram_master;
    import nic8_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic reset;

    // ---------------- request drive (index 0 -> dut0, 1 -> dut3) ----------------
    logic       req_valid [2];
    logic       req_write [2];
    logic [7:0] req_addr  [2];
    logic [7:0] req_wdata [2];

    logic       rdy0, rv0, busy0, oe0, web0;
    logic [7:0] rd0, a0;
    wire  [7:0] d0;
    ram_state_t st0;

    logic       rdy3, rv3, busy3, oe3, web3;
    logic [7:0] rd3, a3;
    wire  [7:0] d3;
    ram_state_t st3;

    ram_master dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(rdy0), .req_write(req_write[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rd_valid(rv0), .rd_data(rd0), .busy(busy0),
        .addr(a0), .data(d0), .outputEnable(oe0), .writeEnableBar(web0),
        .dbg_state(st0)
    );

    ram_master #(.WAIT_STATES(3)) dut3 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(rdy3), .req_write(req_write[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rd_valid(rv3), .rd_data(rd3), .busy(busy3),
        .addr(a3), .data(d3), .outputEnable(oe3), .writeEnableBar(web3),
        .dbg_state(st3)
    );

    // ---------------- RAM models ----------------
    logic [7:0] mem0 [256];
    logic [7:0] mem3 [256];
    logic       pre3_en;
    logic [7:0] pre3_addr, pre3_data;

    assign d0 = oe0 ? mem0[a0] : 8'bz;
    assign d3 = oe3 ? mem3[a3] : 8'bz;

    always @(posedge clk) begin
        if (!web0) mem0[a0] <= d0;
    end

    always @(posedge clk) begin
        if (pre3_en) mem3[pre3_addr] <= pre3_data;
        else if (!web3) mem3[a3] <= d3;
    end

    // ---------------- scoreboard state ----------------
    int vectors = 0;
    int miscompares = 0;
    int last_wait;
    logic [7:0] exp_q0 [$];
    logic [7:0] exp_q3 [$];
    int         lat_q0 [$];
    int         lat_q3 [$];
    time        at_q0  [$];
    time        at_q3  [$];
    logic [7:0] mdl [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic ready_of(input int u);
        return (u == 0) ? rdy0 : rdy3;
    endfunction

    function automatic logic busy_of(input int u);
        return (u == 0) ? busy0 : busy3;
    endfunction

    // ---------------- driver tasks (called at a negedge) ----------------
    // Returns at the negedge following the accepting edge.
    task automatic send(input int u, input logic w, input logic [7:0] a,
                        input logic [7:0] wd, input logic [7:0] exp_rd);
        int  guard;
        int  lat;
        guard = 0;
        req_valid[u] = 1'b1;
        req_write[u] = w;
        req_addr[u]  = a;
        req_wdata[u] = wd;
        while (ready_of(u) !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        last_wait = guard;
        if (guard >= 200) begin
            chk("send_ready_timeout", 32'(ready_of(u)), 1);
            req_valid[u] = 1'b0;
            return;
        end
        // Idle with an empty buffer: fixed latency applies; otherwise queued.
        lat = (busy_of(u) == 1'b0) ? ((u == 0) ? 3 : 6) : -1;
        @(posedge clk);
        if (!w) begin
            if (u == 0) begin
                exp_q0.push_back(exp_rd); lat_q0.push_back(lat); at_q0.push_back($time);
            end else begin
                exp_q3.push_back(exp_rd); lat_q3.push_back(lat); at_q3.push_back($time);
            end
        end
        @(negedge clk);
        req_valid[u] = 1'b0;
    endtask

    task automatic wait_idle(input int u);
        int guard;
        guard = 0;
        while (busy_of(u) !== 1'b0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) chk("idle_timeout", 32'(busy_of(u)), 0);
    endtask

    // Write on dut0 from idle, checking the bus through SETUP/STROBE/HOLD.
    task automatic write_checked(input logic [7:0] a, input logic [7:0] wd);
        int low;
        low = 0;
        wait_idle(0);
        send(0, 1'b1, a, wd, 8'h00);
        for (int c = 0; c < 3; c++) begin
            chk("wr_addr_stable", 32'(a0), 32'(a));
            chk("wr_data_driven", 32'(d0), 32'(wd));
            chk("wr_oe_low", 32'(oe0), 0);
            chk("wr_web_phase", 32'(web0), (c == 1) ? 32'd0 : 32'd1);
            if (web0 === 1'b0) low++;
            @(negedge clk);
        end
        chk("wr_web_low_cycles", 32'(low), 1);
        chk("wr_web_idle_high", 32'(web0), 1);
    endtask

    // ---------------- monitors / scoreboard pop ----------------
    always @(negedge clk) begin
        logic [7:0] e;
        int         l;
        time        t;
        if (!reset) begin
            if (rv0) begin
                if (exp_q0.size() == 0) begin
                    chk("rd0_unexpected", 32'(rv0), 0);
                end else begin
                    e = exp_q0.pop_front(); l = lat_q0.pop_front(); t = at_q0.pop_front();
                    chk("rd0_data", 32'(rd0), 32'(e));
                    if (l >= 0) chk("rd0_latency", 32'(($time + 5 - t) / 10), 32'(l));
                end
            end
            chk("bus0_oe_we_overlap", 32'(oe0 && !web0), 0);
            if (oe0) chk("bus0_undriven_on_read", 32'(d0), 32'(mem0[a0]));
        end
    end

    always @(negedge clk) begin
        logic [7:0] e;
        int         l;
        time        t;
        if (!reset) begin
            if (rv3) begin
                if (exp_q3.size() == 0) begin
                    chk("rd3_unexpected", 32'(rv3), 0);
                end else begin
                    e = exp_q3.pop_front(); l = lat_q3.pop_front(); t = at_q3.pop_front();
                    chk("rd3_data", 32'(rd3), 32'(e));
                    if (l >= 0) chk("rd3_latency", 32'(($time + 5 - t) / 10), 32'(l));
                end
            end
            chk("bus3_oe_we_overlap", 32'(oe3 && !web3), 0);
            if (oe3) chk("bus3_undriven_on_read", 32'(d3), 32'(mem3[a3]));
        end
    end

    // ---------------- directed sequence ----------------
    initial begin
        int         cnt;
        logic       rw;
        logic [7:0] ra, rdat;

        reset = 1'b1;
        pre3_en = 1'b0; pre3_addr = 8'h00; pre3_data = 8'h00;
        for (int u = 0; u < 2; u++) begin
            req_valid[u] = 1'b0; req_write[u] = 1'b0; req_addr[u] = 8'h00; req_wdata[u] = 8'h00;
        end
        repeat (3) @(negedge clk);

        // Reset values
        chk("rst_ready", 32'(rdy0), 1);
        chk("rst_rd_valid", 32'(rv0), 0);
        chk("rst_rd_data", 32'(rd0), 0);
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_addr", 32'(a0), 0);
        chk("rst_oe", 32'(oe0), 0);
        chk("rst_web", 32'(web0), 1);
        chk("rst_state", 32'(st0), 32'(IDLE));
        chk("rst3_web", 32'(web3), 1);
        chk("rst3_ready", 32'(rdy3), 1);
        reset = 1'b0;
        @(negedge clk);

        // Write 0xA5 to 0x3C, then read it back
        write_checked(8'h3C, 8'hA5);
        send(0, 1'b0, 8'h3C, 8'h00, 8'hA5);
        wait_idle(0);
        repeat (2) @(negedge clk);
        chk("rd_data_held", 32'(rd0), 32'hA5);

        // Back-to-back with req_valid held high
        wait_idle(0);
        send(0, 1'b1, 8'h10, 8'h11, 8'h00);
        send(0, 1'b1, 8'h11, 8'h22, 8'h00);
        chk("b2b_ready_low", 32'(rdy0), 0);
        chk("b2b_busy", 32'(busy0), 1);
        send(0, 1'b0, 8'h10, 8'h00, 8'h11);
        chk("b2b_ready_wait", 32'(last_wait), 3);
        send(0, 1'b0, 8'h11, 8'h00, 8'h22);
        wait_idle(0);

        // Address/data stability at the address extremes
        write_checked(8'h00, 8'hC3);
        write_checked(8'hFF, 8'h3C);
        send(0, 1'b0, 8'hFF, 8'h00, 8'h3C);
        send(0, 1'b0, 8'h00, 8'h00, 8'hC3);
        wait_idle(0);
        repeat (2) @(negedge clk);

        // Reset in the middle of a write strobe
        send(0, 1'b1, 8'h77, 8'h3E, 8'h00);
        @(negedge clk);
        chk("pre_rst_web_low", 32'(web0), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_web", 32'(web0), 1);
        chk("midrst_oe", 32'(oe0), 0);
        chk("midrst_data_released", 32'((d0 === 8'hzz) || (d0 === 8'h00)), 1);
        chk("midrst_ready", 32'(rdy0), 1);
        chk("midrst_rd_data", 32'(rd0), 0);
        chk("midrst_rd_valid", 32'(rv0), 0);
        chk("midrst_busy", 32'(busy0), 0);
        chk("midrst_addr", 32'(a0), 0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Three wait states: read preloaded 0x00
        pre3_addr = 8'h00; pre3_data = 8'h5A; pre3_en = 1'b1;
        @(negedge clk);
        pre3_en = 1'b0;
        send(1, 1'b0, 8'h00, 8'h00, 8'h5A);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (oe3 === 1'b1) cnt++;
            @(negedge clk);
        end
        chk("ws3_oe_cycles", 32'(cnt), 5);

        wait_idle(1);
        send(1, 1'b1, 8'h80, 8'h99, 8'h00);
        cnt = 0;
        for (int c = 0; c < 8; c++) begin
            if (web3 === 1'b0) cnt++;
            @(negedge clk);
        end
        chk("ws3_web_low_cycles", 32'(cnt), 4);
        send(1, 1'b0, 8'h80, 8'h00, 8'h99);
        wait_idle(1);

        // Random read/write mix on a 16-byte window
        for (int i = 0; i < 16; i++) begin
            ra = 8'h40 + 8'(i);
            rdat = 8'($urandom_range(0, 255));
            mdl[ra] = rdat;
            send(0, 1'b1, ra, rdat, 8'h00);
        end
        for (int i = 0; i < 200; i++) begin
            rw = ($urandom_range(0, 1) == 1);
            ra = 8'h40 + 8'($urandom_range(0, 15));
            rdat = 8'($urandom_range(0, 255));
            if (rw) mdl[ra] = rdat;
            send(0, rw, ra, rdat, mdl[ra]);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Drain outstanding reads
        cnt = 0;
        while ((exp_q0.size() != 0 || exp_q3.size() != 0) && cnt < 200) begin
            @(negedge clk);
            cnt++;
        end
        chk("q0_drained", 32'(exp_q0.size()), 0);
        chk("q3_drained", 32'(exp_q3.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ram_master.md
# ram_master

Bus initiator for the 256-byte data RAM. It accepts byte read/write requests from the core over a valid/ready handshake. It sequences the RAM-side pins (address, tri-state data, output enable, active-low write enable) through setup, strobe and hold phases, and returns read data with a one-cycle valid pulse. It sits between the CPU/loader logic and the `ram_NET` instance, and is the sole driver of that instance's control inputs.

## Interface
- `WAIT_STATES`, default 0: extra strobe cycles per access (0..15).
- `clk` in 1: system clock; the RAM write strobe is qualified by `clk` high inside the RAM wrapper.
- `reset` in 1: synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted on a cycle where valid and ready are both high.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in 8: byte address.
- `req_wdata` in 8: write data.
- `rd_valid` out 1: one-cycle pulse; `rd_data` holds the byte read.
- `rd_data` out 8: last read result, held until the next read completes.
- `busy` out 1: high whenever the FSM is not IDLE or the skid register is full.
- `addr` out 8: RAM address.
- `data` inout 8: RAM data bus, driven only during write phases, `8'bz` otherwise.
- `outputEnable` out 1: RAM read enable, active-high.
- `writeEnableBar` out 1: RAM write enable, active-low.

## Operation
- States: IDLE, SETUP, STROBE, HOLD.
- **IDLE:** if a request is buffered, or one is accepted this cycle, load it into the active registers and go to SETUP the next cycle.
- **SETUP (1 cycle):**
  - `addr` driven.
  - Write: `data` driven, `writeEnableBar`=1, `outputEnable`=0.
  - Read: `outputEnable`=1, `data` undriven.
- **STROBE (1+WAIT_STATES cycles, counted by a 4-bit down-counter):**
  - Write: `writeEnableBar`=0, `data` driven.
  - Read: `outputEnable`=1; `data` is sampled into `rd_data` on the final STROBE edge.
- **HOLD (1 cycle):**
  - `writeEnableBar`=1 and `outputEnable`=0.
  - Write: `addr` and `data` still driven.
  - Read: `rd_valid`=1 and the bus is released.
  - Next state is IDLE.
- **Bus turnaround:** HOLD always separates a read's `outputEnable` from the next access's SETUP. `data` is never driven in any cycle where `outputEnable`=1. No back-to-back merging.
- **Skid register:** one entry. `req_ready` = skid empty. A request arriving while the FSM is active goes to the skid register, which drains on the next IDLE. Requests are served strictly in order.
- `writeEnableBar` and `outputEnable` come straight from flops, so they are glitch-free. They are never asserted together.
- **Reset:**
  - State IDLE, skid register empty.
  - `req_ready`=1, `rd_valid`=0, `rd_data`=0, `busy`=0.
  - `addr`=0, `outputEnable`=0, `writeEnableBar`=1, `data` undriven.
- **Reset mid-access:** the access is abandoned and the outputs return to reset values on the next edge. A write in STROBE may have partially completed; that is permitted and the loss is not reported.

## Timing
- Access occupancy is 3+WAIT_STATES cycles, from the SETUP cycle through the HOLD cycle.
- A request accepted at edge n enters SETUP at n+1. A read's `rd_valid` is high in cycle n+3+WAIT_STATES.
- Throughput: one access per 4+WAIT_STATES cycles (includes the IDLE cycle).
- A request presented while IDLE with the skid register empty is accepted immediately.
- A request arriving on the same edge that HOLD exits is captured in the skid register. It starts the cycle after IDLE.
- `rd_data` is stable from the `rd_valid` cycle onward.

## Structure
- Shared package `nic8_pkg`:
  - state enum `ram_state_t` (IDLE, SETUP, STROBE, HOLD);
  - request struct `{write, addr[7:0], wdata[7:0]}`;
  - constant `RAM_WS_MAX`=15.
- Sub-module `ram_req_skid`: the one-entry valid/ready buffer. The FSM and tri-state drive stay in `ram_master`.

## Test plan
- **Reset:** assert `reset` for 2 cycles mid-STROBE of a write. Next edge: `writeEnableBar`=1, `outputEnable`=0, `data`=z, `req_ready`=1, `rd_data`=0.
- **Write then read, WAIT_STATES=0:** write 0xA5 to address 0x3C, then read 0x3C. `writeEnableBar` is low exactly 1 cycle. `rd_valid` pulses 3 cycles after acceptance with `rd_data`=0xA5.
- **Wait states, WAIT_STATES=3:** read of address 0x00 (preloaded 0x5A). `outputEnable` is high for 5 cycles and `rd_valid` arrives 6 cycles after acceptance with 0x5A.
- **Back-to-back:** hold `req_valid` high for write 0x10←0x11, write 0x11←0x22, read 0x10. The second request lands in the skid register and `req_ready` drops for one access. Read returns 0x11, in order.
- **Contention check:** across a 200-access random read/write mix, the bench asserts every cycle that `data` is never driven while `outputEnable`=1, and that `outputEnable` and `writeEnableBar`=0 never coincide.
- **Address stability:** during any write, `addr` and `data` are unchanged from SETUP through HOLD. Verified with addresses 0x00 and 0xFF.
